// File: rtl/piso_pkg.sv
// piso_pkg: state encoding and parity helper for the PISO transmitter
package piso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t;
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/piso_shift_out.sv
// piso_shift_out: parallel-in/serial-out transmitter with valid/ready load and last flag
// Define PISO_PARITY_EN to append an even-parity bit after each frame (word width n <= 64).
module piso_shift_out
    import piso_pkg::*;
#(
    parameter int n         = 8,
    parameter bit MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [n-1:0] d,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sdo,
    output logic         sdo_n,
    output logic         sdo_valid,
    output logic         last,
    output logic         busy
);
    localparam int CW = $clog2(n);
    piso_state_t state;
    logic [n-1:0] shreg;
    logic [CW-1:0] cnt;
    logic accept;
    logic final_bit;
`ifdef PISO_PARITY_EN
    logic par;
`endif
    assign load_ready = en & (state == IDLE | last);
    assign accept     = load_valid & load_ready;
    assign busy       = state != IDLE;
    assign sdo_n      = ~sdo;
    assign final_bit  = cnt == CW'(n - 1);
    // sdo is registered, so the next bit is taken from the pre-shift register contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            last      <= 1'b0;
`ifdef PISO_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (accept) begin
            state     <= SHIFT;
            shreg     <= d;
            cnt       <= '0;
            sdo       <= MSB_FIRST ? d[n-1] : d[0];
            sdo_valid <= 1'b1;
            last      <= 1'b0;
`ifdef PISO_PARITY_EN
            par       <= even_parity(64'(d));
`endif
        end else if (en && state == SHIFT && !final_bit) begin
            cnt   <= cnt + 1'b1;
            shreg <= MSB_FIRST ? {shreg[n-2:0], 1'b0} : {1'b0, shreg[n-1:1]};
            sdo   <= MSB_FIRST ? shreg[n-2] : shreg[1];
`ifndef PISO_PARITY_EN
            last  <= cnt == CW'(n - 2);
`endif
        end
`ifdef PISO_PARITY_EN
        else if (en && state == SHIFT) begin
            state <= PARITY;
            sdo   <= par;
            last  <= 1'b1;
        end
`endif
        else if (en && state != IDLE) begin
            state     <= IDLE;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            last      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_shift_out.sv
// tb_piso_shift_out: directed bench for piso_shift_out (LSB-first main instance, MSB-first second)
module tb_piso_shift_out;
    localparam int n = 8;
`ifdef PISO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = n + PB;

    logic clk = 1'b0, rst = 1'b0, en = 1'b1;
    logic [n-1:0] d = '0, m_d = '0;
    logic load_valid = 1'b0, m_load_valid = 1'b0;
    logic load_ready, sdo, sdo_n, sdo_valid, last, busy;
    logic m_load_ready, m_sdo, m_sdo_n, m_sdo_valid, m_last, m_busy;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    piso_shift_out #(.n(n), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d), .load_valid(load_valid),
        .load_ready(load_ready), .sdo(sdo), .sdo_n(sdo_n), .sdo_valid(sdo_valid),
        .last(last), .busy(busy)
    );

    piso_shift_out #(.n(n), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .d(m_d), .load_valid(m_load_valid),
        .load_ready(m_load_ready), .sdo(m_sdo), .sdo_n(m_sdo_n), .sdo_valid(m_sdo_valid),
        .last(m_last), .busy(m_busy)
    );

    function automatic logic exp_bit(input logic [n-1:0] w, input int i);
        return i < n ? w[i] : ^w;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sdo, sdo_n, sdo_valid, last, busy, load_ready} !== 6'b010001) begin
            errors++;
            $display("FAIL reset {sdo,sdo_n,valid,last,busy,ready}: got %b want 010001",
                     {sdo, sdo_n, sdo_valid, last, busy, load_ready});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // load_valid stays high with junk data mid-frame; it must be ignored until last
    task automatic test_frame(input logic [n-1:0] w);
        logic e;
        d = w;
        load_valid = 1'b1;
        @(negedge clk);
        d = '0;
        for (int i = 0; i < FL; i++) begin
            load_valid = i < FL - 1;
            e = exp_bit(w, i);
            checks++;
            if ({sdo, sdo_n, sdo_valid, last, load_ready} !== {e, ~e, 1'b1, i == FL - 1, i == FL - 1}) begin
                errors++;
                $display("FAIL frame %h bit %0d {sdo,sdo_n,valid,last,ready}: got %b want %b", w, i,
                         {sdo, sdo_n, sdo_valid, last, load_ready}, {e, ~e, 1'b1, i == FL - 1, i == FL - 1});
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        checks++;
        if ({sdo, sdo_n, sdo_valid, last, busy, load_ready} !== 6'b010001) begin
            errors++;
            $display("FAIL frame %h idle after: got %b want 010001", w,
                     {sdo, sdo_n, sdo_valid, last, busy, load_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [n-1:0] a = 8'hA5, b = 8'h3C;
        logic e;
        d = a;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i == FL - 1) begin
                d = b;
                load_valid = 1'b1;
            end else load_valid = 1'b0;
            e = exp_bit(i < FL ? a : b, i % FL);
            checks++;
            if ({sdo, sdo_valid} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL b2b bit %0d {sdo,valid}: got %b want %b", i, {sdo, sdo_valid}, {e, 1'b1});
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        checks++;
        if ({sdo_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b idle {valid,busy}: got %b want 00", {sdo_valid, busy});
        end
    endtask

    task automatic test_enable_hold();
        logic [n-1:0] w = 8'hA5;
        logic e;
        d = w;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            e = exp_bit(w, i);
            checks++;
            if ({sdo, sdo_valid} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL en_hold bit %0d {sdo,valid}: got %b want %b", i, {sdo, sdo_valid}, {e, 1'b1});
            end
            if (i == 3) begin
                en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({sdo, sdo_valid, load_ready, busy} !== 4'b0101) begin
                        errors++;
                        $display("FAIL en_hold frozen %0d {sdo,valid,ready,busy}: got %b want 0101", k,
                                 {sdo, sdo_valid, load_ready, busy});
                    end
                end
                en = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if ({sdo_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL en_hold idle {valid,busy}: got %b want 00", {sdo_valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        d = 8'hA5;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({sdo, sdo_valid, busy} !== 3'b111) begin
            errors++;
            $display("FAIL rst_mid bit5 {sdo,valid,busy}: got %b want 111", {sdo, sdo_valid, busy});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({sdo, sdo_n, sdo_valid, last, busy, load_ready} !== 6'b010001) begin
            errors++;
            $display("FAIL rst_mid async: got %b want 010001", {sdo, sdo_n, sdo_valid, last, busy, load_ready});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb();
        logic [n-1:0] ws[2] = '{8'hA5, 8'h3C};
        logic e;
        for (int j = 0; j < 2; j++) begin
            m_d = ws[j];
            m_load_valid = 1'b1;
            @(negedge clk);
            m_load_valid = 1'b0;
            for (int i = 0; i < n; i++) begin
                e = ws[j][n-1-i];
                checks++;
                if ({m_sdo, m_sdo_n, m_sdo_valid} !== {e, ~e, 1'b1}) begin
                    errors++;
                    $display("FAIL msb %h bit %0d {sdo,sdo_n,valid}: got %b want %b", ws[j], i,
                             {m_sdo, m_sdo_n, m_sdo_valid}, {e, ~e, 1'b1});
                end
                @(negedge clk);
            end
            repeat (PB) @(negedge clk);
            checks++;
            if ({m_busy, m_sdo_valid} !== 2'b00) begin
                errors++;
                $display("FAIL msb %h idle {busy,valid}: got %b want 00", ws[j], {m_busy, m_sdo_valid});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        test_frame(8'h07);
        test_back_to_back();
        test_enable_hold();
        test_reset_mid();
        test_frame(8'hFF);
        test_msb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
